cell_free_list: RTL
===================

Name: cell_free_list

Overview:
- Parametrised free-list manager for the shared cell buffer.
- Owns every cell index not currently held by a packet chain.
- Hands indices to the ingress cell writer on alloc and takes them back from the egress reader on free.
- Generalises the fixed 4096-cell layout: cell count, pointer width, reserved indices and watermark are all parameters. Adds a post-reset init sweep, occupancy count and error flags.

Parameters:
- NUM_BLOCKS, 4096: total cells in the buffer.
- ADDR_W, $clog2(NUM_BLOCKS): index width; must match the footer next_idx field.
- RSVD_LOW, 1: indices 0..RSVD_LOW-1 are never handed out; index 0 is the null next pointer.
- LOW_WM, 8: almost_empty asserts when free count <= LOW_WM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- init_done  out  1  high once the init sweep completes; stays high until rst
- alloc_valid  out  1  a free index is presented
- alloc_ready  in  1  consumer takes alloc_idx
- alloc_idx  out  ADDR_W  index being handed out
- free_valid  in  1  index being returned
- free_ready  out  1  manager accepts free_idx
- free_idx  in  ADDR_W  returned index
- free_count  out  ADDR_W+1  number of indices currently held
- almost_empty  out  1  free_count <= LOW_WM
- err_overflow  out  1  one-cycle pulse: free arrived while list full
- err_dbl_free  out  1  one-cycle pulse: illegal free (feature only, else 0)

Behaviour:
- Reset values: init_done=0, alloc_valid=0, free_ready=0, free_count=0, errors=0, FSM=INIT, init pointer=RSVD_LOW.
- INIT state:
  - Pushes one index per cycle, ascending from RSVD_LOW to NUM_BLOCKS-1.
  - Sweep takes NUM_BLOCKS-RSVD_LOW cycles.
  - Ports closed: alloc_valid=0, free_ready=0.
- RUN state:
  - Entered the cycle after the last push; init_done=1 from that same cycle.
  - free_ready=1 in RUN.
  - alloc_valid=1 whenever free_count>0.
- Storage: FIFO of indices in a 1-cycle-read RAM, plus a head prefetch stage so alloc_idx is registered.
  - Sustained one alloc per cycle while free_count>=2.
  - Alloc order is strict FIFO: first alloc after reset = RSVD_LOW, then RSVD_LOW+1, and so on.
- Handshakes:
  - Alloc transfers on alloc_valid&alloc_ready.
  - Free transfers on free_valid&free_ready.
  - alloc_idx is stable while alloc_valid&!alloc_ready.
- Count rules: alloc only: -1; free only: +1; both in the same cycle: unchanged.
- Free-to-alloc latency:
  - A freed index may appear on alloc_idx no earlier than 2 cycles after its free handshake.
  - With free_count=0, a free in cycle N gives alloc_valid=1 at N+2.
- Full condition: free_count == NUM_BLOCKS-RSVD_LOW.
  - A free while full (and no alloc that cycle) is dropped.
  - err_overflow pulses the next cycle; count unchanged.
- Empty: alloc_valid=0; alloc_ready ignored.
- free_count and almost_empty are registered and update the cycle after the handshake.
- rst mid-operation: all state reinitialised; INIT sweep restarts; outstanding allocations are forgotten.

Optional Feature:
- Macro: CELL_FREE_LIST_DBL_FREE_CHK_EN.
- Defined:
  - NUM_BLOCKS-bit owned bitmap: set on alloc handshake, cleared on accepted free.
  - A free is illegal if its index is not owned, is < RSVD_LOW, or is >= NUM_BLOCKS.
  - An illegal free is dropped and err_dbl_free pulses the next cycle.
  - Same-cycle alloc of X and free of X: the free is checked against the pre-cycle bitmap, so it is illegal.
- Undefined: no bitmap; err_dbl_free tied 0; every free is accepted subject only to the full check.

Decomposition:
- Add to mem_pkg:
  - cell_idx_t (logic [ADDR_W-1:0]);
  - NULL_IDX = 0;
  - RSVD_LOW default;
  - count width constant.
- Sub-module cell_idx_ram: simple dual-port RAM, NUM_BLOCKS x ADDR_W, 1-cycle read.
- FSM, pointers, prefetch and checker stay in cell_free_list.

Test Plan (NUM_BLOCKS=16, RSVD_LOW=1, LOW_WM=2):
- Reset, then idle:
  - init_done rises 15 cycles after rst drops;
  - free_count=15; almost_empty=0.
- alloc_ready held high for 15 cycles:
  - indices 1..15 in order, back-to-back;
  - alloc_valid=0 afterwards; free_count=0; almost_empty=1 once count<=2.
- Empty list, free idx 7 in cycle N:
  - alloc_valid=1 at N+2 with alloc_idx=7;
  - free_count=1.
- Full list, alloc and free of idx 3 in the same cycle:
  - count stays 15; no error;
  - idx 3 later emerges as the last-queued entry.
- Full list, free idx 5 with no alloc:
  - err_overflow pulse; count stays 15.
- Feature on:
  - free idx 4 while never allocated -> err_dbl_free pulse, dropped;
  - free idx 0 -> err_dbl_free pulse;
  - rst asserted mid-traffic -> count=0, init sweep restarts.

Source files
------------

// File: rtl/cell_free_list_pkg.sv
// Shared definitions for the cell free-list manager and its index RAM.
// Optional double-free checker is enabled by CELL_FREE_LIST_DBL_FREE_CHK_EN.
package cell_free_list_pkg;

    localparam int unsigned DEF_NUM_BLOCKS = 4096;
    localparam int unsigned DEF_ADDR_W     = $clog2(DEF_NUM_BLOCKS);
    localparam int unsigned DEF_RSVD_LOW   = 1;
    localparam int unsigned DEF_LOW_WM     = 8;

    typedef logic [DEF_ADDR_W-1:0] cell_idx_t;

    // Index 0 terminates a packet chain, so it is never handed out.
    localparam cell_idx_t NULL_IDX = '0;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // The count must hold 0..NUM_BLOCKS inclusive.
    function automatic int unsigned count_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/cell_free_list_ram.sv
// Simple dual-port index RAM: one write port, one read port, 1-cycle registered read.
module cell_idx_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cell_free_list.sv
// Free-list manager for the shared cell buffer: FIFO of free indices with a post-reset init sweep.
// Define CELL_FREE_LIST_DBL_FREE_CHK_EN to add the owned-bitmap double-free checker.
module cell_free_list
    import cell_free_list_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS),
    parameter int unsigned RSVD_LOW   = DEF_RSVD_LOW,
    parameter int unsigned LOW_WM     = DEF_LOW_WM
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic              alloc_valid,
    input  logic              alloc_ready,
    output logic [ADDR_W-1:0] alloc_idx,
    input  logic              free_valid,
    output logic              free_ready,
    input  logic [ADDR_W-1:0] free_idx,
    output logic [ADDR_W:0]   free_count,
    output logic              almost_empty,
    output logic              err_overflow,
    output logic              err_dbl_free
);

    localparam int unsigned       CNT_W    = count_w(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BLOCKS - RSVD_LOW);
    localparam logic [CNT_W-1:0]  WM_CNT   = CNT_W'(LOW_WM);

    logic [0:0]        state;
    logic              run;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  ram_cnt;
    logic [CNT_W-1:0]  ram_cnt_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              head_valid;
    logic              alloc_fire;
    logic              free_fire;
    logic              free_legal;
    logic              free_acc;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_data;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign run         = (state == ST_RUN);
    assign init_done   = run;
    assign free_ready  = run;
    assign alloc_valid = run & head_valid;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign free_fire   = free_valid & free_ready;
    assign full        = (cnt == FULL_CNT);
    assign free_count  = cnt;

    // A free into a full list only fits when the head leaves in the same cycle.
    assign free_acc = free_fire & free_legal & (~full | alloc_fire);
    assign wr_en    = ~run | free_acc;
    assign wr_data  = run ? free_idx : init_ptr;

    // The RAM output register is the head stage: it reloads whenever the head is empty or consumed.
    assign rd_en = (ram_cnt != '0) & (~head_valid | alloc_fire);

    always_comb begin
        cnt_nxt = cnt;
        if (wr_en && !alloc_fire) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (!wr_en && alloc_fire) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        if (wr_en && !rd_en) begin
            ram_cnt_nxt = ram_cnt + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            ram_cnt_nxt = ram_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            init_ptr     <= ADDR_W'(RSVD_LOW);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            cnt          <= '0;
            head_valid   <= 1'b0;
            almost_empty <= 1'b1;
            err_overflow <= 1'b0;
        end else begin
            if (!run) begin
                init_ptr <= next_ptr(init_ptr);
                if (init_ptr == LAST_PTR) begin
                    state <= ST_RUN;
                end
            end
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (rd_en) begin
                head_valid <= 1'b1;
            end else if (alloc_fire) begin
                head_valid <= 1'b0;
            end
            ram_cnt      <= ram_cnt_nxt;
            cnt          <= cnt_nxt;
            almost_empty <= (cnt_nxt <= WM_CNT);
            err_overflow <= free_fire & free_legal & full & ~alloc_fire;
        end
    end

    cell_idx_ram #(
        .DEPTH (NUM_BLOCKS),
        .WIDTH (ADDR_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (alloc_idx)
    );

`ifdef CELL_FREE_LIST_DBL_FREE_CHK_EN
    logic [NUM_BLOCKS-1:0] owned;
    logic                  idx_in_range;

    assign idx_in_range = ({1'b0, free_idx} >= CNT_W'(RSVD_LOW)) &&
                          ({1'b0, free_idx} <  CNT_W'(NUM_BLOCKS));
    // Checked against the pre-cycle bitmap, so freeing the index being allocated is illegal.
    assign free_legal   = idx_in_range && owned[free_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            owned        <= '0;
            err_dbl_free <= 1'b0;
        end else begin
            if (alloc_fire) begin
                owned[alloc_idx] <= 1'b1;
            end
            if (free_acc) begin
                owned[free_idx] <= 1'b0;
            end
            err_dbl_free <= free_fire & ~free_legal;
        end
    end
`else
    assign free_legal   = 1'b1;
    assign err_dbl_free = 1'b0;
`endif

endmodule
